// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue slot: ALU selects, RV32I major opcodes,
// branch kinds and the slot state.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_PASSB = 4'd2;
    localparam logic [3:0] ALU_SLL   = 4'd3;
    localparam logic [3:0] ALU_SRL   = 4'd4;
    localparam logic [3:0] ALU_SRA   = 4'd5;
    localparam logic [3:0] ALU_XOR   = 4'd6;
    localparam logic [3:0] ALU_OR    = 4'd7;
    localparam logic [3:0] ALU_AND   = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_SLTU  = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JUMP
    } br_kind_e;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate extraction: every format decoded in parallel, sign-extended.
module imm_gen (
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm_i,
    output logic [31:0] o_imm_s,
    output logic [31:0] o_imm_b,
    output logic [31:0] o_imm_u,
    output logic [31:0] o_imm_j
);
    assign o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign o_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign o_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign o_imm_u = {i_instr[31:12], 12'b0};
    assign o_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
endmodule

// File: rtl/alu_issue.sv
// Single-entry ALU issue slot: decodes RV32I operands into a registered slot
// and resolves branches/jumps one cycle after the slot transfers.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [3:0]      out_alu_sel,
    output logic            out_illegal,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_zero,
    input  logic            flush,
    output logic            br_valid,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target
);
    // Handshake: a beat moves on a rising edge when valid & ready are both high;
    // valid never depends on ready, and a presented entry holds until taken.
    slot_state_e     r_state;
    logic [XLEN-1:0] r_op1, r_op2, r_tgt, r_br_target;
    logic [3:0]      r_sel;
    logic            r_ill, r_br_valid, r_br_taken;
    br_kind_e        r_kind;

    logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_op1, w_op2, w_tgt, w_jalr_sum;
    logic [3:0]      w_sel;
    logic            w_ill, w_acc, w_xfer, w_taken;
    br_kind_e        w_kind;
    logic [6:0]      w_opc, w_f7;
    logic [2:0]      w_f3;

    imm_gen u_imm_gen (
        .i_instr (in_instr),
        .o_imm_i (w_imm_i),
        .o_imm_s (w_imm_s),
        .o_imm_b (w_imm_b),
        .o_imm_u (w_imm_u),
        .o_imm_j (w_imm_j)
    );

    assign w_opc      = in_instr[6:0];
    assign w_f3       = in_instr[14:12];
    assign w_f7       = in_instr[31:25];
    assign w_jalr_sum = in_rs1 + w_imm_i;

    always_comb begin
        w_op1  = '0;
        w_op2  = '0;
        w_sel  = ALU_ADD;
        w_ill  = 1'b0;
        w_kind = BR_NONE;
        w_tgt  = '0;
        case (w_opc)
            OPC_OP: begin
                w_op1 = in_rs1;
                w_op2 = in_rs2;
                w_ill = (w_f7 != 7'h00) && !((w_f7 == 7'h20) && (w_f3 == 3'd0 || w_f3 == 3'd5));
                case (w_f3)
                    3'd0:    w_sel = w_f7[5] ? ALU_SUB : ALU_ADD;
                    3'd1:    w_sel = ALU_SLL;
                    3'd2:    w_sel = ALU_SLT;
                    3'd3:    w_sel = ALU_SLTU;
                    3'd4:    w_sel = ALU_XOR;
                    3'd5:    w_sel = w_f7[5] ? ALU_SRA : ALU_SRL;
                    3'd6:    w_sel = ALU_OR;
                    default: w_sel = ALU_AND;
                endcase
            end
            OPC_OPIMM: begin
                w_op1 = in_rs1;
                w_op2 = w_imm_i;
                case (w_f3)
                    3'd0: w_sel = ALU_ADD;
                    3'd1: begin
                        w_sel = ALU_SLL;
                        w_op2 = {27'b0, in_instr[24:20]};
                        w_ill = (w_f7 != 7'h00);
                    end
                    3'd2: w_sel = ALU_SLT;
                    3'd3: w_sel = ALU_SLTU;
                    3'd4: w_sel = ALU_XOR;
                    3'd5: begin
                        w_sel = w_f7[5] ? ALU_SRA : ALU_SRL;
                        w_op2 = {27'b0, in_instr[24:20]};
                        w_ill = (w_f7 != 7'h00) && (w_f7 != 7'h20);
                    end
                    3'd6:    w_sel = ALU_OR;
                    default: w_sel = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                w_sel = ALU_PASSB;
                w_op2 = w_imm_u;
            end
            OPC_AUIPC: begin
                w_op1 = in_pc;
                w_op2 = w_imm_u;
            end
            OPC_LOAD: begin
                w_op1 = in_rs1;
                w_op2 = w_imm_i;
                w_ill = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
            end
            OPC_STORE: begin
                w_op1 = in_rs1;
                w_op2 = w_imm_s;
                w_ill = (w_f3 > 3'd2);
            end
            OPC_JAL, OPC_JALR: begin
                w_op1  = in_pc;
                w_op2  = 32'd4;
                w_kind = BR_JUMP;
                w_tgt  = (w_opc == OPC_JAL) ? in_pc + w_imm_j : {w_jalr_sum[XLEN-1:1], 1'b0};
                w_ill  = (w_opc == OPC_JALR) && (w_f3 != 3'd0);
            end
            OPC_BRANCH: begin
                w_op1 = in_rs1;
                w_op2 = in_rs2;
                w_tgt = in_pc + w_imm_b;
                case (w_f3)
                    3'd0:    begin w_sel = ALU_SUB;  w_kind = BR_EQ;  end
                    3'd1:    begin w_sel = ALU_SUB;  w_kind = BR_NE;  end
                    3'd4:    begin w_sel = ALU_SLT;  w_kind = BR_LT;  end
                    3'd5:    begin w_sel = ALU_SLT;  w_kind = BR_GE;  end
                    3'd6:    begin w_sel = ALU_SLTU; w_kind = BR_LTU; end
                    3'd7:    begin w_sel = ALU_SLTU; w_kind = BR_GEU; end
                    default: w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_op1  = '0;
            w_op2  = '0;
            w_sel  = ALU_ADD;
            w_kind = BR_NONE;
            w_tgt  = '0;
        end
    end

    // Ordered compares come from the ALU's SLT/SLTU bit so signed overflow is handled.
    always_comb begin
        case (r_kind)
            BR_EQ:          w_taken = alu_zero;
            BR_NE:          w_taken = !alu_zero;
            BR_LT, BR_LTU:  w_taken = alu_res[0];
            BR_GE, BR_GEU:  w_taken = !alu_res[0];
            BR_JUMP:        w_taken = 1'b1;
            default:        w_taken = 1'b0;
        endcase
    end

    assign in_ready    = ((r_state == SLOT_EMPTY) || out_ready) && !flush && !rst;
    assign w_acc       = in_valid && in_ready;
    assign w_xfer      = (r_state == SLOT_FULL) && out_ready;
    assign out_valid   = (r_state == SLOT_FULL);
    assign out_op1     = r_op1;
    assign out_op2     = r_op2;
    assign out_alu_sel = r_sel;
    assign out_illegal = r_ill;
    assign br_valid    = r_br_valid;
    assign br_taken    = r_br_taken;
    assign br_target   = r_br_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SLOT_EMPTY;
            r_op1       <= '0;
            r_op2       <= '0;
            r_sel       <= ALU_ADD;
            r_ill       <= 1'b0;
            r_kind      <= BR_NONE;
            r_tgt       <= '0;
            r_br_valid  <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            r_br_valid <= 1'b0;
            if (flush) begin
                r_state <= SLOT_EMPTY;
            end else begin
                if (w_xfer && (r_kind != BR_NONE)) begin
                    r_br_valid  <= 1'b1;
                    r_br_taken  <= w_taken;
                    r_br_target <= r_tgt;
                end
                if (w_acc) begin
                    r_state <= SLOT_FULL;
                    r_op1   <= w_op1;
                    r_op2   <= w_op2;
                    r_sel   <= w_sel;
                    r_ill   <= w_ill;
                    r_kind  <= w_kind;
                    r_tgt   <= w_tgt;
                end else if (w_xfer) begin
                    r_state <= SLOT_EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed vector table, hand-written multi-cycle
// sequences, then random traffic against an instruction-level reference model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [3:0]  out_alu_sel;
  logic        out_illegal;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        flush;
  logic        br_valid, br_taken;
  logic [31:0] br_target;

  int n_vec = 0;
  int n_bad = 0;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1),
    .out_op2(out_op2), .out_alu_sel(out_alu_sel), .out_illegal(out_illegal),
    .alu_res(alu_res), .alu_zero(alu_zero), .flush(flush),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural ALU responding to the presented slot ----------------
  function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return b;
      4'd3:    return a << b[4:0];
      4'd4:    return a >> b[4:0];
      4'd5:    return $unsigned($signed(a) >>> b[4:0]);
      4'd6:    return a ^ b;
      4'd7:    return a | b;
      4'd8:    return a & b;
      4'd9:    return {31'b0, $signed(a) < $signed(b)};
      4'd10:   return {31'b0, a < b};
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    alu_res  = ref_alu(out_alu_sel, out_op1, out_op2);
    alu_zero = (alu_res == 32'h0);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // kind: 0 = not a control transfer, 1 = conditional branch, 2 = jump
  typedef struct {
    logic        ill;
    logic [3:0]  sel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] tgt;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    int          kind;
  } ent_t;

  function automatic ent_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
    ent_t e;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] ii, is, ib, iu, ij, sum;
    logic        ok;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    // immediates as signed integer sums of their fields
    ii = 32'(ins[30:20]) - 32'(ins[31]) * 32'd2048;
    is = 32'(ins[11:7]) + 32'(ins[30:25]) * 32'd32 - 32'(ins[31]) * 32'd2048;
    ib = 32'(ins[11:8]) * 32'd2 + 32'(ins[30:25]) * 32'd32 + 32'(ins[7]) * 32'd2048
         - 32'(ins[31]) * 32'd4096;
    iu = 32'(ins[31:12]) * 32'd4096;
    ij = 32'(ins[30:21]) * 32'd2 + 32'(ins[20]) * 32'd2048 + 32'(ins[19:12]) * 32'd4096
         - 32'(ins[31]) * 32'd1048576;
    e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3;
    e.op1 = 32'h0; e.op2 = 32'h0; e.sel = 4'd0; e.tgt = 32'h0; e.kind = 0;
    ok = 1'b1;
    case (opc)
      7'h33: begin
        e.op1 = rs1; e.op2 = rs2;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        case (f3)
          3'd0: e.sel = (f7 == 7'h20) ? 4'd1 : 4'd0;
          3'd1: e.sel = 4'd3;
          3'd2: e.sel = 4'd9;
          3'd3: e.sel = 4'd10;
          3'd4: e.sel = 4'd6;
          3'd5: e.sel = (f7 == 7'h20) ? 4'd5 : 4'd4;
          3'd6: e.sel = 4'd7;
          default: e.sel = 4'd8;
        endcase
      end
      7'h13: begin
        e.op1 = rs1; e.op2 = ii;
        case (f3)
          3'd0: e.sel = 4'd0;
          3'd1: begin e.sel = 4'd3; e.op2 = 32'(ins[24:20]); ok = (f7 == 7'h00); end
          3'd2: e.sel = 4'd9;
          3'd3: e.sel = 4'd10;
          3'd4: e.sel = 4'd6;
          3'd5: begin
            e.sel = (f7 == 7'h20) ? 4'd5 : 4'd4;
            e.op2 = 32'(ins[24:20]);
            ok = (f7 == 7'h00) || (f7 == 7'h20);
          end
          3'd6: e.sel = 4'd7;
          default: e.sel = 4'd8;
        endcase
      end
      7'h37: begin e.sel = 4'd2; e.op2 = iu; end
      7'h17: begin e.op1 = pc; e.op2 = iu; end
      7'h03: begin e.op1 = rs1; e.op2 = ii; ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
      7'h23: begin e.op1 = rs1; e.op2 = is; ok = (f3 <= 3'd2); end
      7'h6F: begin e.op1 = pc; e.op2 = 32'd4; e.kind = 2; e.tgt = pc + ij; end
      7'h67: begin
        e.op1 = pc; e.op2 = 32'd4; e.kind = 2;
        sum = rs1 + ii;
        e.tgt = sum - 32'(sum[0]);
        ok = (f3 == 3'd0);
      end
      7'h63: begin
        e.op1 = rs1; e.op2 = rs2; e.kind = 1; e.tgt = pc + ib;
        case (f3)
          3'd0, 3'd1: e.sel = 4'd1;
          3'd4, 3'd5: e.sel = 4'd9;
          3'd6, 3'd7: e.sel = 4'd10;
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    e.ill = !ok;
    if (!ok) begin
      e.op1 = 32'h0; e.op2 = 32'h0; e.sel = 4'd0; e.kind = 0;
    end
    return e;
  endfunction

  // branch outcome straight from the architectural comparison of the source registers
  function automatic logic model_taken(input ent_t e);
    if (e.kind == 2) return 1'b1;
    case (e.f3)
      3'd0:    return e.rs1 == e.rs2;
      3'd1:    return e.rs1 != e.rs2;
      3'd4:    return $signed(e.rs1) < $signed(e.rs2);
      3'd5:    return $signed(e.rs1) >= $signed(e.rs2);
      3'd6:    return e.rs1 < e.rs2;
      default: return e.rs1 >= e.rs2;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opcs [12];
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63, 7'h7F, 7'h0F, 7'h00};
    r = $urandom();
    r[6:0] = opcs[$urandom_range(0, 11)];
    if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_in(input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    in_rs1   = rs1;
    in_rs2   = rs2;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0; in_rs1 = 32'h0; in_rs2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_br_valid", 32'(br_valid), 32'd0);
    chk("rst_op1", out_op1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr, pc, rs1, rs2, op1, op2;
    logic [3:0]  sel;
    logic        ill;
  } vec_t;

  vec_t tbl [12];

  task automatic run_table();
    tbl[0]  = '{32'hFFD08093, 32'h0,   32'd5,  32'd9,  32'd5,   32'hFFFFFFFD, 4'd0,  1'b0}; // addi -3
    tbl[1]  = '{32'h40000033, 32'h0,   32'h11, 32'h22, 32'h11,  32'h22,       4'd1,  1'b0}; // sub
    tbl[2]  = '{32'h40305013, 32'h0,   32'h11, 32'h22, 32'h11,  32'd3,        4'd5,  1'b0}; // srai 3
    tbl[3]  = '{32'h40301013, 32'h0,   32'h11, 32'h22, 32'h0,   32'h0,        4'd0,  1'b1}; // slli bad funct7
    tbl[4]  = '{32'h0000007F, 32'h0,   32'h11, 32'h22, 32'h0,   32'h0,        4'd0,  1'b1}; // unknown opcode
    tbl[5]  = '{32'h12345037, 32'h0,   32'h11, 32'h22, 32'h0,   32'h12345000, 4'd2,  1'b0}; // lui
    tbl[6]  = '{32'h00001017, 32'h200, 32'h11, 32'h22, 32'h200, 32'h1000,     4'd0,  1'b0}; // auipc
    tbl[7]  = '{32'hFE002C23, 32'h0,   32'h11, 32'h22, 32'h11,  32'hFFFFFFF8, 4'd0,  1'b0}; // sw -8
    tbl[8]  = '{32'h0000006F, 32'h100, 32'h11, 32'h22, 32'h100, 32'd4,        4'd0,  1'b0}; // jal
    tbl[9]  = '{32'h00004033, 32'h0,   32'h11, 32'h22, 32'h11,  32'h22,       4'd6,  1'b0}; // xor
    tbl[10] = '{32'h00103013, 32'h0,   32'h11, 32'h22, 32'h11,  32'd1,        4'd10, 1'b0}; // sltiu 1
    tbl[11] = '{32'h00007063, 32'h0,   32'h11, 32'h22, 32'h11,  32'h22,       4'd10, 1'b0}; // bgeu
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_in(tbl[i].instr, tbl[i].pc, tbl[i].rs1, tbl[i].rs2);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_sel", i), 32'(out_alu_sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_op1", i), out_op1, tbl[i].op1);
      chk($sformatf("tbl%0d_op2", i), out_op2, tbl[i].op2);
      chk($sformatf("tbl%0d_ill", i), 32'(out_illegal), 32'(tbl[i].ill));
    end
    @(negedge clk);
  endtask

  // ---------------- hand-written multi-cycle sequences ----------------
  task automatic seq_blt();
    out_ready = 1'b1;
    @(negedge clk);
    drive_in(32'h00004863, 32'h100, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("blt_sel", 32'(out_alu_sel), 32'd9);
    @(negedge clk);
    #1;
    chk("blt_br_valid", 32'(br_valid), 32'd1);
    chk("blt_br_taken", 32'(br_taken), 32'd1);
    chk("blt_br_target", br_target, 32'h110);
    chk("blt_slot_empty", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk("blt_pulse_end", 32'(br_valid), 32'd0);
  endtask

  task automatic seq_stall();
    out_ready = 1'b0;
    @(negedge clk);
    drive_in(32'hFFD08093, 32'h0, 32'd5, 32'd0);
    @(negedge clk);
    drive_in(32'h40000033, 32'h0, 32'd7, 32'd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_op1", out_op1, 32'd5);
      chk("stall_op2", out_op2, 32'hFFFFFFFD);
      chk("stall_sel", 32'(out_alu_sel), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("unstall_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("swap_valid", 32'(out_valid), 32'd1);
    chk("swap_sel", 32'(out_alu_sel), 32'd1);
    chk("swap_op1", out_op1, 32'd7);
    chk("swap_op2", out_op2, 32'd2);
    @(negedge clk);
    #1 chk("swap_drained", 32'(out_valid), 32'd0);
  endtask

  task automatic seq_flush();
    out_ready = 1'b0;
    @(negedge clk);
    drive_in(32'h00000463, 32'h40, 32'h55, 32'h55);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_br_valid", 32'(br_valid), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk("flush_br_later", 32'(br_valid), 32'd0);
  endtask

  task automatic seq_illegal_reset();
    out_ready = 1'b1;
    @(negedge clk);
    drive_in(32'h0000007F, 32'h80, 32'h1234, 32'h5678);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_op1", out_op1, 32'h0);
    chk("ill_op2", out_op2, 32'h0);
    @(negedge clk);
    #1 chk("ill_no_br", 32'(br_valid), 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    drive_in(32'hFFD08093, 32'h0, 32'd5, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("pre_rst_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_op2", out_op2, 32'h0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_in(32'h0000006F, 32'h300, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("first_accept_valid", 32'(out_valid), 32'd1);
    chk("first_accept_op1", out_op1, 32'h300);
  endtask

  // ---------------- randomized traffic against the model ----------------
  ent_t        exp_q [$];
  logic        exp_bv;
  logic        exp_bt;
  logic [31:0] exp_btgt;

  task automatic run_random(input int cycles);
    logic exp_rdy, xfer, acc;
    exp_q.delete();
    exp_bv = 1'b0; exp_bt = 1'b0; exp_btgt = 32'h0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = rand_instr();
      in_pc     = $urandom();
      in_rs1    = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 8));
      in_rs2    = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom();
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      exp_rdy = ((exp_q.size() == 0) || out_ready) && !flush;
      chk("rnd_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("rnd_br_valid", 32'(br_valid), 32'(exp_bv));
      if (exp_q.size() != 0) begin
        chk("rnd_sel", 32'(out_alu_sel), 32'(exp_q[0].sel));
        chk("rnd_op1", out_op1, exp_q[0].op1);
        chk("rnd_op2", out_op2, exp_q[0].op2);
        chk("rnd_ill", 32'(out_illegal), 32'(exp_q[0].ill));
      end
      if (exp_bv) begin
        chk("rnd_br_taken", 32'(br_taken), 32'(exp_bt));
        chk("rnd_br_target", br_target, exp_btgt);
      end
      xfer = (exp_q.size() != 0) && out_ready;
      acc  = in_valid && exp_rdy;
      @(posedge clk);
      exp_bv = 1'b0;
      if (!flush && xfer && exp_q[0].kind != 0) begin
        exp_bv   = 1'b1;
        exp_bt   = model_taken(exp_q[0]);
        exp_btgt = exp_q[0].tgt;
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (xfer) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(model_decode(in_instr, in_pc, in_rs1, in_rs2));
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  // ---------------- main sequence and final report ----------------
  initial begin
    do_reset();
    run_table();
    seq_blt();
    seq_stall();
    seq_flush();
    seq_illegal_reset();
    do_reset();
    run_random(1500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: in_valid in 1, in_ready out 1, in_instr in 32, in_pc in 32, in_rs1 in 32, in_rs2 in 32 (upstream decode handshake plus register-file values).
REQ-004 SHALL have: out_valid out 1, out_ready in 1, out_op1 out 32, out_op2 out 32, out_alu_sel out 4, out_illegal out 1 (ALU-facing issue slot).
REQ-005 SHALL have: alu_res in 32, alu_zero in 1 (combinational ALU result/flag for the slot currently presented).
REQ-006 SHALL have: flush in 1; br_valid out 1, br_taken out 1, br_target out 32 (branch/jump resolution).
REQ-007 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.

Function
REQ-008 alu_sel encoding SHALL be ADD=0, SUB=1, PASSB=2, SLL=3, SRL=4, SRA=5, XOR=6, OR=7, AND=8, SLT=9, SLTU=10.
REQ-009 Slot state SHALL be EMPTY/FULL; out_valid=1 iff FULL.
REQ-010 in_ready SHALL be (EMPTY or out_ready) and not flush and not rst.
REQ-011 Accept (in_valid & in_ready) SHALL register decoded op1/op2/alu_sel/illegal, branch kind and precomputed target; FULL next cycle; latency 1 cycle.
REQ-012 While out_valid & !out_ready, all out_* SHALL hold stable.
REQ-013 Transfer (out_valid & out_ready) without accept SHALL go EMPTY; transfer plus accept in the same cycle SHALL stay FULL with the new entry.
REQ-014 OP (0110011): op1=rs1, op2=rs2; funct3/funct7[5] map to ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
REQ-015 OP-IMM (0010011): op1=rs1, op2=sign-extended I-imm; shifts use op2={27'b0,shamt}; SRAI when funct7[5]=1.
REQ-016 LUI: alu_sel=PASSB, op2={imm[31:12],12'b0}; AUIPC: ADD, op1=pc, op2=U-imm.
REQ-017 LOAD/STORE: ADD, op1=rs1, op2=I-imm or S-imm respectively.
REQ-018 JAL/JALR: ADD, op1=pc, op2=4; target pc+J-imm, or (rs1+I-imm) with bit0 cleared.
REQ-019 BRANCH: op1=rs1, op2=rs2; BEQ/BNE->SUB, BLT/BGE->SLT, BLTU/BGEU->SLTU; target pc+B-imm.
REQ-020 Unknown opcode or invalid funct: out_illegal=1, alu_sel=ADD, op1=op2=0; the entry still transfers normally.
REQ-021 On transfer of a branch or jump, br_valid SHALL pulse high for exactly one cycle in the next cycle, with br_target registered.
REQ-022 br_taken: BEQ=alu_zero, BNE=!alu_zero, BLT/BLTU=alu_res[0], BGE/BGEU=!alu_res[0], JAL/JALR=1; sampled at transfer.
REQ-023 alu_zero SHALL only be used for equality; signed compares SHALL use the SLT result, never an op1-op2 sign bit, because that bit ignores overflow.
REQ-024 Non-branch transfers and illegal entries SHALL NOT pulse br_valid.
REQ-025 flush SHALL go EMPTY next cycle and suppress any br_valid pending from a same-cycle transfer; flush wins over simultaneous accept and transfer.

Reset
REQ-026 While rst=1: state EMPTY, all outputs 0 (in_ready=0, br_* =0, out_* =0), asynchronously; reset mid-stall SHALL discard the held entry.
REQ-027 First accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-028 Package alu_pkg SHALL hold the alu_sel constants, the RV32I opcode constants and the branch-kind enum.
REQ-029 Sub-module imm_gen (instr -> I/S/B/U/J immediates, sign-extended) SHALL be the only sub-module.

Verification
REQ-030 ADDI x, rs1=5, imm=-3 -> next cycle out_valid=1, alu_sel=0, op1=5, op2=0xFFFFFFFD.
REQ-031 BLT at pc=0x100, rs1=0xFFFFFFFF, rs2=1, B-imm=+16, alu_res=1 -> br_valid pulse with br_taken=1, br_target=0x110.
REQ-032 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> transfer and accept in one cycle.
REQ-033 flush asserted in the transfer cycle of a BEQ with alu_zero=1 -> br_valid stays 0 and out_valid=0 next cycle.
REQ-034 opcode 0x7F -> out_illegal=1, op1=op2=0, no br_valid; rst pulse while FULL -> all outputs 0 immediately.
